ctrl_seq: RTL and testbench

Multi-cycle control sequencer for the core datapath. It fetches 9-bit instructions, decodes the 4-bit `op_mne` opcode, and drives the ALU, register-file write and data-memory handshake one phase at a time. It owns the PC and the comparison flags used by conditional branches. It sits between instruction memory and the ALU/regfile/data-memory datapath, and reports halt (DON) or an illegal opcode to the top level.

---
 rtl/ctrl_seq.sv | 217 +++++++++++++++++++++
 tb/tb_ctrl_seq.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_seq
// Purpose  : Multi-cycle control sequencer. Fetches 9-bit instructions,
//            decodes the 4-bit opcode ir[8:5], and sequences the ALU,
//            register-file write and data-memory handshake one phase at a
//            time. Owns the PC and the compare flags used by branches.
// Ports    : clk, rst_n      - clock (rising edge), async active-low reset
//            start           - pulse: (re)start execution at PC 0
//            instr           - instruction memory data for address pc
//            pc, ir          - current PC and latched instruction
//            alu_op, alu_en  - ALU operation and enable (EXEC only)
//            cmp_eq/lt/gt    - ALU compare results, sampled in CMP EXEC
//            reg_we, wb_sel  - regfile write strobe, 0=ALU / 1=memory data
//            mem_req, mem_we - data-memory request and store select
//            mem_ready       - data-memory completion
//            done, illegal   - halted on DON / on opcode 15
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_seq #(
  parameter int PC_W = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [8:0]      instr,
  output logic [PC_W-1:0] pc,
  output logic [8:0]      ir,
  output logic [3:0]      alu_op,
  output logic            alu_en,
  input  logic            cmp_eq,
  input  logic            cmp_lt,
  input  logic            cmp_gt,
  output logic            reg_we,
  output logic            wb_sel,
  output logic            mem_req,
  output logic            mem_we,
  input  logic            mem_ready,
  output logic            done,
  output logic            illegal
);

  localparam logic [3:0] OP_CMP = 4'd6;
  localparam logic [3:0] OP_BE  = 4'd7;
  localparam logic [3:0] OP_BL  = 4'd8;
  localparam logic [3:0] OP_BG  = 4'd9;
  localparam logic [3:0] OP_BA  = 4'd10;
  localparam logic [3:0] OP_LD  = 4'd12;
  localparam logic [3:0] OP_ST  = 4'd13;
  localparam logic [3:0] OP_DON = 4'd14;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic            r_flagEq, r_flagLt, r_flagGt;
  logic            w_nextFlagEq, w_nextFlagLt, w_nextFlagGt;
  logic [PC_W-1:0] w_nextPc;
  logic [8:0]      w_nextIr;
  logic            w_nextDone, w_nextIllegal;
  logic [3:0]      w_opcode;
  logic [PC_W-1:0] w_pcInc;
  logic [PC_W-1:0] w_branchTarget;
  logic            w_taken;

  assign w_opcode = ir[8:5];
  // Both sums wrap naturally modulo 2^PC_W.
  assign w_pcInc        = pc + {{(PC_W-1){1'b0}}, 1'b1};
  assign w_branchTarget = pc + {{(PC_W-5){ir[4]}}, ir[4:0]};

  always_comb begin
    w_taken = 1'b0;
    case (w_opcode)
      OP_BA:   w_taken = 1'b1;
      OP_BE:   w_taken = r_flagEq;
      OP_BL:   w_taken = r_flagLt;
      OP_BG:   w_taken = r_flagGt;
      default: w_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      pc       <= '0;
      ir       <= '0;
      done     <= 1'b0;
      illegal  <= 1'b0;
      r_flagEq <= 1'b0;
      r_flagLt <= 1'b0;
      r_flagGt <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      pc       <= w_nextPc;
      ir       <= w_nextIr;
      done     <= w_nextDone;
      illegal  <= w_nextIllegal;
      r_flagEq <= w_nextFlagEq;
      r_flagLt <= w_nextFlagLt;
      r_flagGt <= w_nextFlagGt;
    end
  end

  always_comb begin
    w_nextState   = r_state;
    w_nextPc      = pc;
    w_nextIr      = ir;
    w_nextDone    = done;
    w_nextIllegal = illegal;
    w_nextFlagEq  = r_flagEq;
    w_nextFlagLt  = r_flagLt;
    w_nextFlagGt  = r_flagGt;
    alu_en        = 1'b0;
    alu_op        = 4'd0;
    reg_we        = 1'b0;
    wb_sel        = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_nextState = S_FETCH;
        end
      end

      S_FETCH: begin
        w_nextIr    = instr;
        w_nextState = S_DECODE;
      end

      S_DECODE: begin
        case (w_opcode)
          4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd11: begin
            w_nextState = S_EXEC;
          end
          OP_LD, OP_ST: begin
            w_nextState = S_MEM;
          end
          OP_BE, OP_BL, OP_BG, OP_BA: begin
            // Branches resolve here so the target is fetched next cycle.
            w_nextPc    = w_taken ? w_branchTarget : w_pcInc;
            w_nextState = S_FETCH;
          end
          OP_DON: begin
            w_nextDone  = 1'b1;
            w_nextState = S_HALT;
          end
          default: begin
            w_nextIllegal = 1'b1;
            w_nextState   = S_HALT;
          end
        endcase
      end

      S_EXEC: begin
        alu_en = 1'b1;
        alu_op = w_opcode;
        if (w_opcode == OP_CMP) begin
          w_nextFlagEq = cmp_eq;
          w_nextFlagLt = cmp_lt;
          w_nextFlagGt = cmp_gt;
        end else begin
          reg_we = 1'b1;
        end
        w_nextPc    = w_pcInc;
        w_nextState = S_FETCH;
      end

      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (w_opcode == OP_ST);
        if (mem_ready) begin
          if (w_opcode == OP_ST) begin
            w_nextPc    = w_pcInc;
            w_nextState = S_FETCH;
          end else begin
            w_nextState = S_WB;
          end
        end
      end

      S_WB: begin
        reg_we      = 1'b1;
        wb_sel      = 1'b1;
        w_nextPc    = w_pcInc;
        w_nextState = S_FETCH;
      end

      S_HALT: begin
        if (start) begin
          w_nextDone    = 1'b0;
          w_nextIllegal = 1'b0;
          w_nextFlagEq  = 1'b0;
          w_nextFlagLt  = 1'b0;
          w_nextFlagGt  = 1'b0;
          w_nextPc      = '0;
          w_nextState   = S_FETCH;
        end
      end

      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_seq
// Purpose  : Directed self-checking bench for ctrl_seq. A behavioural
//            instruction memory feeds instr from pc; each phase is stepped
//            explicitly and compared against hand-computed values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ctrl_seq;

  localparam int PC_W = 10;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [8:0]      instr;
  logic [PC_W-1:0] pc;
  logic [8:0]      ir;
  logic [3:0]      alu_op;
  logic            alu_en;
  logic            cmp_eq, cmp_lt, cmp_gt;
  logic            reg_we, wb_sel;
  logic            mem_req, mem_we, mem_ready;
  logic            done, illegal;

  logic [8:0] imem [0:(1<<PC_W)-1];
  int checkCnt = 0;
  int errCnt   = 0;

  ctrl_seq #(.PC_W(PC_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .instr     (instr),
    .pc        (pc),
    .ir        (ir),
    .alu_op    (alu_op),
    .alu_en    (alu_en),
    .cmp_eq    (cmp_eq),
    .cmp_lt    (cmp_lt),
    .cmp_gt    (cmp_gt),
    .reg_we    (reg_we),
    .wb_sel    (wb_sel),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_ready (mem_ready),
    .done      (done),
    .illegal   (illegal)
  );

  assign instr = imem[pc];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] enc(input int op, input int off);
    logic [8:0] w;
    w = {op[3:0], off[4:0]};
    return w;
  endfunction

  task automatic clearMem();
    for (int i = 0; i < (1 << PC_W); i++) imem[i] = enc(14, 0);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    start = 1'b0;
    mem_ready = 1'b0;
    cmp_eq = 1'b0; cmp_lt = 1'b0; cmp_gt = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    mem_ready = 1'b0;
    cmp_eq = 1'b0; cmp_lt = 1'b0; cmp_gt = 1'b0;
    clearMem();

    // ---------------- reset values, idle ignores spurious inputs
    doReset();
    checkVal("rst_pc", pc, 0);
    checkVal("rst_ir", ir, 0);
    checkVal("rst_alu_en", alu_en, 0);
    checkVal("rst_alu_op", alu_op, 0);
    checkVal("rst_reg_we", reg_we, 0);
    checkVal("rst_mem_req", mem_req, 0);
    checkVal("rst_done", done, 0);
    checkVal("rst_illegal", illegal, 0);
    mem_ready = 1'b1; cmp_eq = 1'b1;
    tick(); tick();
    mem_ready = 1'b0; cmp_eq = 1'b0;
    checkVal("idle_pc", pc, 0);
    checkVal("idle_mem_req", mem_req, 0);

    // ---------------- program A: ALU, CMP, flag persistence, BE taken
    imem[0] = enc(0, 0);    // ADD
    imem[1] = enc(6, 0);    // CMP
    imem[2] = enc(2, 0);    // XOR
    imem[3] = enc(8, 3);    // BL +3
    imem[4] = enc(9, 3);    // BG +3
    imem[5] = enc(7, 30);   // BE -2
    pulseStart();
    checkVal("a_fetch_pc", pc, 0);
    tick();                                   // DECODE ADD
    checkVal("a_ir_add", ir, enc(0, 0));
    checkVal("a_dec_alu_en", alu_en, 0);
    tick();                                   // EXEC ADD
    checkVal("a_add_alu_en", alu_en, 1);
    checkVal("a_add_reg_we", reg_we, 1);
    checkVal("a_add_wb_sel", wb_sel, 0);
    tick();                                   // FETCH 1
    checkVal("a_pc1", pc, 1);
    tick(); tick();                           // EXEC CMP
    checkVal("a_cmp_alu_op", alu_op, 6);
    checkVal("a_cmp_reg_we", reg_we, 0);
    cmp_eq = 1'b1;
    tick();                                   // FETCH 2
    cmp_eq = 1'b0; cmp_lt = 1'b1; cmp_gt = 1'b1; mem_ready = 1'b1;
    tick(); tick();                           // EXEC XOR, compares ignored
    checkVal("a_xor_alu_op", alu_op, 2);
    checkVal("a_xor_mem_req", mem_req, 0);
    tick();
    checkVal("a_pc3", pc, 3);
    tick(); tick();                           // BL not taken
    checkVal("a_bl_nt_pc", pc, 4);
    tick(); tick();                           // BG not taken
    checkVal("a_bg_nt_pc", pc, 5);
    tick(); tick();                           // BE -2 taken
    checkVal("a_be_taken_pc", pc, 3);
    checkVal("a_be_ir", ir, enc(7, 30));

    // ---------------- program B: BG taken, BE not taken, DON, restart, illegal
    doReset();
    clearMem();
    imem[0] = enc(6, 0);    // CMP
    imem[1] = enc(9, 4);    // BG +4
    imem[5] = enc(7, 30);   // BE -2
    imem[6] = enc(14, 0);   // DON
    pulseStart();
    tick(); tick();                           // EXEC CMP
    cmp_gt = 1'b1;
    tick();
    cmp_gt = 1'b0;
    checkVal("b_pc1", pc, 1);
    tick(); tick();
    checkVal("b_bg_taken_pc", pc, 5);
    tick(); tick();
    checkVal("b_be_nt_pc", pc, 6);
    start = 1'b1;                             // held through FETCH/DECODE
    tick();                                   // DECODE DON
    checkVal("b_dec_done", done, 0);
    checkVal("b_dec_pc", pc, 6);
    tick();                                   // HALT
    start = 1'b0;
    checkVal("b_done", done, 1);
    checkVal("b_done_ill", illegal, 0);
    tick(); tick();
    checkVal("b_halt_pc", pc, 6);
    checkVal("b_halt_done", done, 1);
    imem[0] = enc(9, 3);    // BG +3 (flags cleared: not taken)
    imem[1] = enc(15, 0);   // illegal
    pulseStart();
    checkVal("b_restart_done", done, 0);
    checkVal("b_restart_pc", pc, 0);
    tick(); tick();
    checkVal("b_flags_cleared_pc", pc, 1);
    tick(); tick();                           // HALT illegal
    checkVal("b_illegal", illegal, 1);
    checkVal("b_ill_done", done, 0);
    checkVal("b_ill_pc", pc, 1);
    pulseStart();
    checkVal("b_ill_clear", illegal, 0);
    checkVal("b_ill_restart_pc", pc, 0);

    // ---------------- program C: PC wrap on branches and increment
    doReset();
    clearMem();
    imem[0]    = enc(10, 16);  // BA -16 -> 1008
    imem[1008] = enc(10, 12);  // BA +12 -> 1020
    imem[1020] = enc(10, 15);  // BA +15 -> 11
    imem[11]   = enc(10, 20);  // BA -12 -> 1023
    imem[1023] = enc(0, 0);    // ADD -> 0
    pulseStart();
    tick(); tick();
    checkVal("c_back_wrap", pc, 1008);
    tick(); tick();
    checkVal("c_pc1020", pc, 1020);
    tick(); tick();
    checkVal("c_fwd_wrap", pc, 11);
    tick(); tick();
    checkVal("c_pc1023", pc, 1023);
    tick(); tick(); tick();
    checkVal("c_inc_wrap", pc, 0);

    // ---------------- program D: LD with wait, ST immediate, reset mid-MEM
    doReset();
    clearMem();
    imem[0] = enc(12, 0);   // LD
    imem[1] = enc(13, 0);   // ST
    imem[2] = enc(12, 0);   // LD
    pulseStart();
    tick();                                   // DECODE LD
    for (int i = 0; i < 4; i++) begin
      tick();
      checkVal($sformatf("d_ld_req%0d", i), mem_req, 1);
      checkVal($sformatf("d_ld_we%0d", i), mem_we, 0);
      checkVal($sformatf("d_ld_pc%0d", i), pc, 0);
      if (i == 3) mem_ready = 1'b1;
    end
    tick();                                   // WB
    checkVal("d_wb_reg_we", reg_we, 1);
    checkVal("d_wb_sel", wb_sel, 1);
    checkVal("d_wb_mem_req", mem_req, 0);
    tick();                                   // FETCH 1 (7 cycles total)
    checkVal("d_ld_next_pc", pc, 1);
    tick();                                   // DECODE ST, ready high ignored
    checkVal("d_st_dec_pc", pc, 1);
    tick();                                   // MEM ST, ready already high
    checkVal("d_st_req", mem_req, 1);
    checkVal("d_st_we", mem_we, 1);
    checkVal("d_st_reg_we", reg_we, 0);
    tick();
    mem_ready = 1'b0;
    checkVal("d_st_next_pc", pc, 2);
    checkVal("d_st_done_req", mem_req, 0);
    tick(); tick();                           // MEM LD, waiting
    checkVal("d_ld2_req", mem_req, 1);
    rst_n = 1'b0;
    #1;
    checkVal("d_rst_req", mem_req, 0);
    checkVal("d_rst_pc", pc, 0);
    checkVal("d_rst_ir", ir, 0);
    checkVal("d_rst_reg_we", reg_we, 0);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    checkVal("d_idle_req", mem_req, 0);
    pulseStart();
    checkVal("d_restart_pc", pc, 0);
    tick();
    checkVal("d_restart_ir", ir, enc(12, 0));

    $display("Simulation finished: %0d checks, %0d errors", checkCnt, errCnt);
    $finish;
  end

endmodule
`default_nettype wire
